// File: rtl/mips64_pkg.sv
// Shared definitions for the MIPS64 memory-side blocks.
package mips64_pkg;

    localparam int REG_SZ = 64;

    // Access size encoding carried on req_size.
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    // Responder request/response sequencing.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } resp_state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous 64-bit RAM with per-byte write enables and a
// registered read port. Contents are deliberately not reset.
module mem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [7:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH];

    // One access per enabled cycle: byte-enabled write, or read into rdata.
    // rdata holds its value while en is low, which keeps responses stable.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 8; b++) begin
                    if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, fixed latency, served from
// an internal byte-addressable array.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; valid must not depend on ready, and once rsp_valid rises the response
// fields hold until the edge on which rsp_ready is seen high.
module mem_responder
    import mips64_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [63:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output resp_state_e       dbg_state
);

    localparam int AW = $clog2(DEPTH);

    resp_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    size_e       size_q, size_d;
    logic        signed_q, signed_d;
    logic [63:0] wdata_q, wdata_d;

    logic        ram_en;
    logic [63:0] ram_rdata;
    logic [2:0]  off;
    logic [5:0]  sh;
    logic        acc_err;
    logic [7:0]  be_base;
    logic [7:0]  be;
    logic [63:0] rd_sh;
    logic [63:0] load_ext;

    // Request state registers; reset returns to IDLE and drops any pending access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            size_q   <= SZ_B;
            signed_q <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
        end
    end

    // Error, lane and byte-enable decode from the latched request.
    always_comb begin
        off     = addr_q[2:0];
        sh      = {off, 3'b000};
        acc_err = |addr_q[63:AW+3];
        be_base = 8'h00;
        case (size_q)
            SZ_B: be_base = 8'h01;
            SZ_H: begin be_base = 8'h03; acc_err = acc_err | addr_q[0];    end
            SZ_W: begin be_base = 8'h0f; acc_err = acc_err | (|addr_q[1:0]); end
            SZ_D: begin be_base = 8'hff; acc_err = acc_err | (|addr_q[2:0]); end
            default: be_base = 8'h00;
        endcase
        be = be_base << off;
    end

    // Load lane extraction with optional sign extension (dword ignores signed).
    always_comb begin
        rd_sh    = ram_rdata >> sh;
        load_ext = rd_sh;
        case (size_q)
            SZ_B: load_ext = signed_q ? {{56{rd_sh[7]}}, rd_sh[7:0]}   : {56'b0, rd_sh[7:0]};
            SZ_H: load_ext = signed_q ? {{48{rd_sh[15]}}, rd_sh[15:0]} : {48'b0, rd_sh[15:0]};
            SZ_W: load_ext = signed_q ? {{32{rd_sh[31]}}, rd_sh[31:0]} : {32'b0, rd_sh[31:0]};
            default: load_ext = rd_sh;
        endcase
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        size_d    = size_q;
        signed_d  = signed_q;
        wdata_d   = wdata_q;
        ram_en    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    addr_d   = req_addr;
                    size_d   = size_e'(req_size);
                    signed_d = req_signed;
                    wdata_d  = req_wdata;
                    cnt_d    = 4'(LATENCY - 1);
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    // Commit edge: the array is touched only for legal accesses.
                    ram_en  = !acc_err;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response fields, zero outside RESP; data only for successful loads.
    always_comb begin
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        if (state_q == ST_RESP) begin
            rsp_err = acc_err;
            if (!acc_err && !we_q) rsp_rdata = load_ext;
        end
    end

    assign dbg_state = state_q;

    mem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (we_q),
        .be    (be),
        .addr  (addr_q[AW+2:3]),
        .wdata (wdata_q << sh),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at LATENCY=2 (main) and LATENCY=1.
module tb_mem_responder;
  import mips64_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = '0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [63:0] req_wdata = '0;

  logic        req_valid_1 = 1'b0, req_valid_2 = 1'b0;
  logic        rsp_ready_1 = 1'b0, rsp_ready_2 = 1'b0;
  logic        req_ready_1, req_ready_2;
  logic        rsp_valid_1, rsp_valid_2;
  logic [63:0] rsp_rdata_1, rsp_rdata_2;
  logic        rsp_err_1, rsp_err_2;
  resp_state_e dbg_state_1, dbg_state_2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  mem_responder #(.DEPTH(1024), .LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_2), .req_ready(req_ready_2),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_signed(req_signed), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_2), .rsp_ready(rsp_ready_2),
    .rsp_rdata(rsp_rdata_2), .rsp_err(rsp_err_2), .dbg_state(dbg_state_2)
  );

  mem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_1), .req_ready(req_ready_1),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_signed(req_signed), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1),
    .rsp_rdata(rsp_rdata_1), .rsp_err(rsp_err_1), .dbg_state(dbg_state_1)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic we, input logic [63:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [63:0] wdata,
                         input logic [63:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.size = size; v.sgn = sgn; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // Waits for the response after an accept edge, checks latency and fields,
  // then completes the response handshake.
  task automatic wait_rsp(input int which, input logic [63:0] exp_rd, input logic exp_err,
                          input int exp_lat, input string name);
    int lat = 0;
    logic got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      got = (which == 1) ? rsp_valid_1 : rsp_valid_2;
    end
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    @(negedge clk);
    check({name, "_rdata"}, (which == 1) ? rsp_rdata_1 : rsp_rdata_2, exp_rd);
    check({name, "_err"}, 64'((which == 1) ? rsp_err_1 : rsp_err_2), 64'(exp_err));
    if (which == 1) rsp_ready_1 = 1'b1; else rsp_ready_2 = 1'b1;
    @(posedge clk); #1;
    rsp_ready_1 = 1'b0;
    rsp_ready_2 = 1'b0;
    check({name, "_vld_after"}, 64'((which == 1) ? rsp_valid_1 : rsp_valid_2), 64'(0));
    check({name, "_rdy_after"}, 64'((which == 1) ? req_ready_1 : req_ready_2), 64'(1));
  endtask

  task automatic drive_req(input int which, input logic we, input logic [63:0] addr,
                           input logic [1:0] size, input logic sgn, input logic [63:0] wdata);
    @(negedge clk);
    req_we = we; req_addr = addr; req_size = size; req_signed = sgn; req_wdata = wdata;
    if (which == 1) req_valid_1 = 1'b1; else req_valid_2 = 1'b1;
    @(posedge clk); #1;
    req_valid_1 = 1'b0;
    req_valid_2 = 1'b0;
  endtask

  task automatic do_req(input int which, input logic we, input logic [63:0] addr,
                        input logic [1:0] size, input logic sgn, input logic [63:0] wdata,
                        input logic [63:0] exp_rd, input logic exp_err, input string name);
    drive_req(which, we, addr, size, sgn, wdata);
    wait_rsp(which, exp_rd, exp_err, (which == 1) ? 1 : 2, name);
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready_2), 64'(1));
    check("rst_rsp_valid", 64'(rsp_valid_2), 64'(0));
    check("rst_rsp_rdata", rsp_rdata_2, 64'(0));
    check("rst_rsp_err", 64'(rsp_err_2), 64'(0));
    check("rst_state", 64'(dbg_state_2), 64'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 64'(req_ready_2), 64'(1));

    // Vector table for the LATENCY=2 instance
    add_vec(1, 64'h10, 2'd3, 0, 64'h0123_4567_89AB_CDEF, 64'h0, 0);
    add_vec(0, 64'h10, 2'd3, 0, 64'h0, 64'h0123_4567_89AB_CDEF, 0);
    add_vec(0, 64'h13, 2'd0, 1, 64'h0, 64'hFFFF_FFFF_FFFF_FF89, 0);
    add_vec(0, 64'h13, 2'd0, 0, 64'h0, 64'h0000_0000_0000_0089, 0);
    add_vec(0, 64'h14, 2'd2, 1, 64'h0, 64'h0000_0000_0123_4567, 0);
    add_vec(0, 64'h12, 2'd1, 1, 64'h0, 64'hFFFF_FFFF_FFFF_89AB, 0);
    add_vec(0, 64'h16, 2'd1, 1, 64'h0, 64'h0000_0000_0000_0123, 0);
    add_vec(1, 64'h12, 2'd1, 0, 64'hFFFF_0000_0000_BEEF, 64'h0, 0);
    add_vec(0, 64'h10, 2'd3, 0, 64'h0, 64'h0123_4567_BEEF_CDEF, 0);
    add_vec(0, 64'h12, 2'd2, 0, 64'h0, 64'h0, 1);
    add_vec(1, 64'h11, 2'd1, 0, 64'h1234, 64'h0, 1);
    add_vec(1, 64'h2000, 2'd3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1);
    add_vec(0, 64'h2000, 2'd0, 0, 64'h0, 64'h0, 1);
    add_vec(0, 64'h8000_0000_0000_0010, 2'd3, 0, 64'h0, 64'h0, 1);
    add_vec(0, 64'h14, 2'd3, 0, 64'h0, 64'h0, 1);
    add_vec(0, 64'h10, 2'd3, 1, 64'h0, 64'h0123_4567_BEEF_CDEF, 0);
    add_vec(1, 64'h18, 2'd3, 0, 64'h1111_2222_3333_4444, 64'h0, 0);
    add_vec(1, 64'h1F, 2'd0, 0, 64'h0000_0000_0000_00A5, 64'h0, 0);
    add_vec(0, 64'h18, 2'd3, 0, 64'h0, 64'hA511_2222_3333_4444, 0);
    add_vec(0, 64'h1F, 2'd0, 1, 64'h0, 64'hFFFF_FFFF_FFFF_FFA5, 0);
    add_vec(0, 64'h1C, 2'd2, 0, 64'h0, 64'h0000_0000_A511_2222, 0);
    add_vec(1, 64'h1FF8, 2'd3, 0, 64'hCAFE_F00D_1234_8765, 64'h0, 0);
    add_vec(0, 64'h1FFE, 2'd1, 1, 64'h0, 64'hFFFF_FFFF_FFFF_CAFE, 0);

    foreach (vecs[i]) begin
      do_req(2, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].sgn, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // LATENCY=1 instance: store then load, response one edge after accept
    do_req(1, 1, 64'h10, 2'd3, 0, 64'h0123_4567_89AB_CDEF, 64'h0, 0, "l1_store");
    do_req(1, 0, 64'h10, 2'd3, 0, 64'h0, 64'h0123_4567_89AB_CDEF, 0, "l1_load");
    do_req(1, 0, 64'h11, 2'd0, 1, 64'h0, 64'hFFFF_FFFF_FFFF_FFCD, 0, "l1_byte");

    // Response stall: rsp_ready low 5 cycles while req_valid stays high
    @(negedge clk);
    req_we = 0; req_addr = 64'h10; req_size = 2'd3; req_signed = 0;
    req_valid_2 = 1'b1;
    @(posedge clk); #1;
    req_addr = 64'h18;  // changes outside IDLE must not affect the latched request
    begin
      int lat = 0;
      while (!rsp_valid_2 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      check("stall_lat", 64'(lat), 64'(2));
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d_rdata", c), rsp_rdata_2, 64'h0123_4567_BEEF_CDEF);
      check($sformatf("stall%0d_err", c), 64'(rsp_err_2), 64'(0));
      check($sformatf("stall%0d_vld", c), 64'(rsp_valid_2), 64'(1));
      check($sformatf("stall%0d_rdy", c), 64'(req_ready_2), 64'(0));
    end
    @(negedge clk);
    rsp_ready_2 = 1'b1;
    @(posedge clk); #1;
    rsp_ready_2 = 1'b0;
    check("stall_hs_vld", 64'(rsp_valid_2), 64'(0));
    check("stall_hs_rdy", 64'(req_ready_2), 64'(1));
    check("stall_hs_state", 64'(dbg_state_2), 64'(ST_IDLE));
    @(posedge clk); #1;
    check("stall_second_accept", 64'(dbg_state_2), 64'(ST_BUSY));
    req_valid_2 = 1'b0;
    wait_rsp(2, 64'hA511_2222_3333_4444, 0, 2, "stall_next");

    // Reset during BUSY of a store: store dropped, prior contents remain
    drive_req(2, 1, 64'h18, 2'd3, 0, 64'hDEAD_BEEF_DEAD_BEEF);
    @(negedge clk);
    check("mid_busy_state", 64'(dbg_state_2), 64'(ST_BUSY));
    rst_n = 1'b0;
    #1;
    check("rst_mid_vld", 64'(rsp_valid_2), 64'(0));
    check("rst_mid_state", 64'(dbg_state_2), 64'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel_rdy", 64'(req_ready_2), 64'(1));
    do_req(2, 0, 64'h18, 2'd3, 0, 64'h0, 64'hA511_2222_3333_4444, 0, "rst_dropped");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
